// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch requester
//   (if_*) and the data load/store requester (d_*). An accepted request is
//   registered, presented on the mem_* port until mem_ready (or until the
//   watchdog expires), and the response is routed back to its owner.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (in)
//   if_gnt/if_rvalid/if_rdata/if_err   fetch grant and response (out)
//   d_req/d_we/d_be/d_addr/d_wdata     data request (in)
//   d_gnt/d_rvalid/d_rdata/d_err       data grant and response (out)
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   memory request (out)
//   mem_ready/mem_rdata         memory completion and read data (in)
//
// Handshake: a requester raises req with stable attributes and holds it
// until its rvalid pulse. The arbiter answers with a one-cycle gnt pulse in
// the cycle mem_req first rises, then a one-cycle rvalid pulse (with rdata
// and err) the cycle after mem_ready or the watchdog abort. On the memory
// side mem_req and its attributes stay stable until the cycle mem_ready=1;
// mem_ready outside an outstanding access is ignored.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int TIMEOUT       = 255,
  parameter int DATA_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam bit WATCHDOG_ON = (TIMEOUT != 0);
  localparam bit DATA_FIRST  = (DATA_PRIORITY != 0);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic { OWN_FETCH, OWN_DATA } owner_t;

  state_t           state;
  owner_t           owner;
  owner_t           last_grant;
  logic [CNT_W-1:0] cnt;
  logic             pick_data;

  // On a tie, round-robin hands the slot to whoever did not win last time.
  always_comb begin
    pick_data = 1'b0;
    if (d_req && if_req) begin
      pick_data = DATA_FIRST || (last_grant == OWN_FETCH);
    end else begin
      pick_data = d_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_FETCH;
      last_grant <= OWN_FETCH;
      cnt        <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // Grant and response outputs are single-cycle pulses.
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= BUSY;
            mem_req <= 1'b1;
            cnt     <= '0;
            if (pick_data) begin
              owner      <= OWN_DATA;
              last_grant <= OWN_DATA;
              d_gnt      <= 1'b1;
              mem_we     <= d_we;
              mem_be     <= d_be;
              mem_addr   <= d_addr;
              mem_wdata  <= d_wdata;
            end else begin
              owner      <= OWN_FETCH;
              last_grant <= OWN_FETCH;
              if_gnt     <= 1'b1;
              mem_we     <= 1'b0;
              mem_be     <= '1;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
            end
          end
        end
        BUSY: begin
          // mem_ready takes precedence over a watchdog expiring in the same cycle.
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (owner == OWN_DATA) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_we ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else if (WATCHDOG_ON && (cnt == TIMEOUT_VAL)) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (owner == OWN_DATA) begin
              d_rvalid <= 1'b1;
              d_err    <= 1'b1;
            end else begin
              if_rvalid <= 1'b1;
              if_err    <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiters side by side (round-robin and data-priority, both with a
//   4-cycle watchdog) driven by random requesters and a random-latency
//   memory. A transaction-level model keyed on cycle numbers predicts every
//   output on every cycle: grant at accept+1, mem_req from accept+1 through
//   the completion cycle, response the cycle after completion.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_gnt    [2];
  logic          if_rvalid [2];
  logic [DW-1:0] if_rdata  [2];
  logic          if_err    [2];
  logic          d_req     [2];
  logic          d_we      [2];
  logic [BW-1:0] d_be      [2];
  logic [AW-1:0] d_addr    [2];
  logic [DW-1:0] d_wdata   [2];
  logic          d_gnt     [2];
  logic          d_rvalid  [2];
  logic [DW-1:0] d_rdata   [2];
  logic          d_err     [2];
  logic          mem_req   [2];
  logic          mem_we    [2];
  logic [BW-1:0] mem_be    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic          mem_ready [2];
  logic [DW-1:0] mem_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .DATA_PRIORITY(g)
    ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]), .if_err(if_err[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]),
      .d_rdata(d_rdata[g]), .d_err(d_err[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_ready(mem_ready[g]), .mem_rdata(mem_rdata[g])
    );
  end

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rst_prev = 1'b1;

  // reference model: one outstanding transaction record per arbiter
  bit            have    [2];
  int            acc     [2];  // cycle in which the request was accepted
  int            done    [2];  // cycle in which it completed, -1 while open
  bit            owner   [2];  // 0 = fetch, 1 = data
  bit            last    [2];
  bit            m_err   [2];
  logic [DW-1:0] m_rdata [2];
  bit            m_we    [2];
  logic [BW-1:0] m_be    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  bit            pend_if [2];
  bit            pend_d  [2];

  task automatic check(input string tag, input int k, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] cycle %0d: got 0x%0h expected 0x%0h", tag, k, cyc, got, exp);
    end
  endtask

  // driver: one clock cycle for both arbiters
  task automatic cycle(input int if_pct, input int d_pct, input int rdy_pct,
                       input bit idle_rdy, input bit rst_in);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      bit rv, mreq, g_if, g_d, inflight, pick_d;
      // compare outputs of this cycle
      g_if = have[k] && (cyc == acc[k] + 1) && !owner[k];
      g_d  = have[k] && (cyc == acc[k] + 1) && owner[k];
      mreq = have[k] && (cyc > acc[k]) && (done[k] < 0 || cyc <= done[k]);
      rv   = have[k] && (done[k] >= 0) && (cyc == done[k] + 1);
      check("if_gnt", k, if_gnt[k], g_if);
      check("d_gnt", k, d_gnt[k], g_d);
      check("mem_req", k, mem_req[k], mreq);
      check("if_rvalid", k, if_rvalid[k], rv && !owner[k]);
      check("d_rvalid", k, d_rvalid[k], rv && owner[k]);
      check("if_err", k, if_err[k], rv && !owner[k] && m_err[k]);
      check("d_err", k, d_err[k], rv && owner[k] && m_err[k]);
      check("if_rdata", k, if_rdata[k], (rv && !owner[k]) ? m_rdata[k] : '0);
      check("d_rdata", k, d_rdata[k], (rv && owner[k]) ? m_rdata[k] : '0);
      if (mreq) begin
        check("mem_we", k, mem_we[k], m_we[k]);
        check("mem_be", k, mem_be[k], m_be[k]);
        check("mem_addr", k, mem_addr[k], m_addr[k]);
        if (m_we[k]) check("mem_wdata", k, mem_wdata[k], m_wdata[k]);
      end
      if (rst_prev) begin
        check("rst_mem_we", k, mem_we[k], 0);
        check("rst_mem_be", k, mem_be[k], 0);
        check("rst_mem_addr", k, mem_addr[k], 0);
        check("rst_mem_wdata", k, mem_wdata[k], 0);
      end

      // drive inputs for this cycle
      inflight = have[k] && (acc[k] < cyc) && (done[k] < 0);
      mem_rdata[k] = $urandom;
      if (rst_in) begin
        pend_if[k] = 1'b0;
        pend_d[k]  = 1'b0;
        mem_ready[k] = 1'b0;
      end else begin
        if (rv && !owner[k]) pend_if[k] = 1'b0;
        if (rv && owner[k])  pend_d[k]  = 1'b0;
        if (!pend_if[k] && $urandom_range(0, 99) < if_pct) begin
          pend_if[k] = 1'b1;
          if_addr[k] = $urandom;
        end
        if (!pend_d[k] && $urandom_range(0, 99) < d_pct) begin
          pend_d[k]  = 1'b1;
          d_we[k]    = 1'($urandom_range(0, 1));
          d_be[k]    = BW'($urandom_range(0, (1 << BW) - 1));
          d_addr[k]  = $urandom;
          d_wdata[k] = $urandom;
        end
        if (inflight) mem_ready[k] = ($urandom_range(0, 99) < rdy_pct);
        else          mem_ready[k] = idle_rdy && ($urandom_range(0, 1) == 1);
      end
      if_req[k] = pend_if[k];
      d_req[k]  = pend_d[k];

      // advance the model
      if (rst_in) begin
        have[k] = 1'b0;
        last[k] = 1'b0;
      end else begin
        if (inflight) begin
          if (mem_ready[k]) begin
            done[k]    = cyc;
            m_err[k]   = 1'b0;
            m_rdata[k] = m_we[k] ? '0 : mem_rdata[k];
          end else if (cyc == acc[k] + 1 + TO) begin
            done[k]    = cyc;
            m_err[k]   = 1'b1;
            m_rdata[k] = '0;
          end
        end
        if ((!have[k] || (done[k] >= 0 && cyc > done[k])) && (if_req[k] || d_req[k])) begin
          if (if_req[k] && d_req[k]) pick_d = (k == 1) ? 1'b1 : !last[k];
          else                       pick_d = d_req[k];
          have[k]  = 1'b1;
          acc[k]   = cyc;
          done[k]  = -1;
          owner[k] = pick_d;
          last[k]  = pick_d;
          m_we[k]    = pick_d ? d_we[k] : 1'b0;
          m_be[k]    = pick_d ? d_be[k] : '1;
          m_addr[k]  = pick_d ? d_addr[k] : if_addr[k];
          m_wdata[k] = d_wdata[k];
        end
      end
    end
    rst = rst_in;
    rst_prev = rst_in;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = 0; d_req[k] = 0; d_we[k] = 0; d_be[k] = 0;
      d_addr[k] = 0; d_wdata[k] = 0; mem_ready[k] = 0; mem_rdata[k] = 0;
      have[k] = 0; acc[k] = 0; done[k] = -1; owner[k] = 0; last[k] = 0;
      m_err[k] = 0; m_rdata[k] = 0; m_we[k] = 0; m_be[k] = 0; m_addr[k] = 0;
      m_wdata[k] = 0; pend_if[k] = 0; pend_d[k] = 0;
    end
    repeat (3) cycle(0, 0, 0, 0, 1);        // reset state
    repeat (60) cycle(30, 0, 50, 1, 0);     // fetch only
    repeat (60) cycle(0, 30, 50, 1, 0);     // loads and stores only
    repeat (100) cycle(100, 100, 40, 0, 0); // continuous contention
    repeat (40) cycle(0, 100, 0, 1, 0);     // watchdog, late mem_ready while idle
    repeat (300) cycle(40, 40, 30, 1, 0);   // mixed traffic
    // reset in the middle of an access, then fetch traffic again
    for (int i = 0; i < 40; i++) begin
      cycle(100, 0, 0, 0, 0);
      if (mem_req[0] === 1'b1) break;
    end
    check("mid_busy", 0, mem_req[0], 1);
    cycle(0, 0, 0, 0, 1);
    repeat (40) cycle(100, 0, 50, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch requester and its data load/store requester.
- Registers each accepted request, drives a variable-latency ready-handshake memory port and routes the response back to the owning requester.
- Sits between the core and the memory/bus.
- Fairness, optional data priority and a watchdog timeout let stalled fetch or data be handled by the core's stall logic.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- TIMEOUT, 255, max cycles waiting for mem_ready before abort; 0 disables the watchdog
- DATA_PRIORITY, 0, 1 = data always wins ties; 0 = round-robin

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_rvalid
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: fetch response valid
- if_rdata  out  DATA_W  fetched instruction
- if_err  out  1  with if_rvalid: access timed out
- d_req  in  1  data request; held until d_rvalid
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  byte enables for stores
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: data response valid
- d_rdata  out  DATA_W  load data; 0 for stores and errors
- d_err  out  1  with d_rvalid: access timed out
- mem_req  out  1  memory request, held until mem_ready or timeout
- mem_we  out  1  memory write
- mem_be  out  DATA_W/8  memory byte enables; all-ones on reads
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completes the current access in this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ready

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Timeout counter 0.
  - last_grant = FETCH, so the first tie goes to data.
- FSM states:
  - IDLE:
    - No request: stay in IDLE.
    - One request: select it.
    - Both requesting: data if DATA_PRIORITY = 1; otherwise the requester not equal to last_grant.
    - On selection (cycle N):
      - Register addr/we/be/wdata; fetch forces we = 0 and be = all-ones.
      - Set owner and last_grant.
      - Go to BUSY.
      - At N+1: mem_req = 1 and the owner's gnt = 1 for exactly that cycle.
  - BUSY:
    - mem_* outputs held stable.
    - Counter increments each cycle while mem_ready is 0.
    - mem_ready = 1 at cycle K:
      - At K+1: owner's rvalid = 1, rdata = mem_rdata captured at K (0 for stores), err = 0, mem_req = 0, state IDLE.
    - Counter reaches TIMEOUT (TIMEOUT ≠ 0) without mem_ready:
      - Next cycle: mem_req = 0, owner rvalid = 1, err = 1, rdata = 0, state IDLE.
      - mem_ready and the timeout in the same cycle: mem_ready wins, err = 0.
- Response/turnaround timing:
  - rvalid, err and rdata are registered, one-cycle pulses.
  - The IDLE cycle coincident with rvalid may accept a new request, so back-to-back throughput is one access per (memory latency + 2) cycles.
- mem_ready while IDLE is ignored (stale or late responses).
- The non-owner requester sees no gnt or rvalid; its request waits.
- A requester dropping req before its rvalid is a protocol violation; the arbiter completes the access and still pulses rvalid.
- Reset mid-transaction:
  - Abort immediately; all outputs 0, IDLE.
  - No rvalid is issued for the aborted access.
- Counter width is clog2(TIMEOUT+1); the counter clears on entry to BUSY.

Test Plan:
- Fetch only:
  - Stimulus: if_req = 1, if_addr = 0x100 at cycle 0; memory asserts mem_ready at cycle 3 with mem_rdata = 0x00500093.
  - Required: mem_req = 1 and if_gnt = 1 at cycle 1; if_rvalid = 1 with if_rdata = 0x00500093 at cycle 4; mem_req = 0 at cycle 4.
- Store:
  - Stimulus: d_req, d_we = 1, d_be = 0b0011, d_addr = 0x2004, d_wdata = 0xDEADBEEF.
  - Required: mem_we = 1, mem_be = 0b0011, mem_wdata = 0xDEADBEEF held until mem_ready; d_rvalid with d_rdata = 0, d_err = 0.
- Contention, DATA_PRIORITY = 0:
  - Stimulus: both requesters assert continuously from reset.
  - Required: grant order is data, fetch, data, fetch; no requester is granted twice in a row.
- Contention, DATA_PRIORITY = 1:
  - Stimulus: both requesters assert; d_req is re-asserted each cycle after d_rvalid.
  - Required: fetch receives no grant while d_req stays high.
- Timeout:
  - Stimulus: TIMEOUT = 4, d_req load, mem_ready held 0.
  - Required: d_rvalid = 1, d_err = 1, d_rdata = 0 exactly once; mem_req = 0 afterwards; a late mem_ready is ignored.
- Reset mid-access:
  - Stimulus: rst asserted in BUSY before mem_ready.
  - Required: next cycle all outputs 0; no rvalid; the next fetch request behaves as in the fetch-only test.
